sop_fir_pipe: RTL and testbench
===============================

SOP_FIR_PIPE -- requirements
Module: sop_fir_pipe

Interface
REQ-001 Parameter WIDTH, default 4, meaning unsigned data_in width.
REQ-002 Parameter CWIDTH, default WIDTH+1, meaning unsigned coefficient width.
REQ-003 Parameter TAPS, default 4, meaning tap count, legal range 2..16.
REQ-004 Derived constant OW = WIDTH+CWIDTH+clog2(TAPS); AW = clog2(TAPS); LAT = 2+clog2(TAPS).
REQ-005 CLK  input  1  single clock; all state on rising edge.
REQ-006 RESET  input  1  reset, asynchronous, active-low.
REQ-007 clear  input  1  synchronous flush of the data path.
REQ-008 in_valid  input  1  data_in carries a sample this cycle.
REQ-009 data_in  input  WIDTH  sample x[n].
REQ-010 coef_wr  input  1  coefficient write strobe.
REQ-011 coef_addr  input  AW  tap index for the write.
REQ-012 coef_data  input  CWIDTH  coefficient value.
REQ-013 out_valid  output  1  final_out holds a new result.
REQ-014 final_out  output  OW  y[n] = sum over k of c[k]*x[n-k].

Function
REQ-015 The delay line SHALL be TAPS registers that shift only on edges with in_valid=1; tap 0 takes data_in; with in_valid=0 the delay line holds.
REQ-016 Tap k SHALL multiply delay-line word k by coefficient c[k], all unsigned.
REQ-017 Pipeline: edge E0 shifts the sample in; E1 registers TAPS products; each following edge registers one binary adder-tree level; final_out/out_valid update LAT edges after the in_valid edge.
REQ-018 A TAPS value that is not a power of two SHALL zero-pad the tree with no change to LAT.
REQ-019 out_valid SHALL be in_valid delayed LAT cycles through a valid shift register; final_out SHALL hold its last value while out_valid=0.
REQ-020 Accepted throughput: one sample per cycle; there is no backpressure, and gaps in in_valid are preserved in out_valid.
REQ-021 Arithmetic SHALL be full-precision with no truncation; OW is sized so that TAPS*(2^WIDTH-1)*(2^CWIDTH-1) never overflows.
REQ-022 coef_wr=1 with coef_addr<TAPS SHALL write c[coef_addr] at that edge; products registered on the next edge onward use the new value.
REQ-023 coef_wr with coef_addr>=TAPS SHALL be ignored.
REQ-024 Simultaneous coef_wr and in_valid SHALL both take effect; the sample shifted in at that edge reaches the product stage after the write.
REQ-025 clear=1 SHALL zero the delay line, product registers, tree registers, valid pipe, final_out and out_valid at the next edge; coefficients are retained; clear has priority over in_valid.

Reset
REQ-026 RESET low SHALL asynchronously zero the delay line, all coefficients, all pipeline registers, final_out and out_valid.
REQ-027 Deassertion of RESET SHALL be synchronised to CLK through the team's async-assert/sync-deassert reset cell before use internally.
REQ-028 Reset mid-stream SHALL discard all in-flight samples; no out_valid pulse appears within LAT cycles after release unless new samples arrive.

Structure
REQ-029 Package sop_pkg SHALL hold default WIDTH/TAPS constants and the OW/AW/LAT width functions.
REQ-030 One sub-module, sop_tap (delay register, coefficient register, product register), SHALL be instantiated TAPS times in a generate loop.
REQ-031 The adder tree SHALL be generated inline in sop_fir_pipe.

Verification
REQ-032 Impulse: c={1,2,3,4}, in_valid continuous, data_in 1 then 0s -> final_out 1,2,3,4,0 with the first value out_valid 3 cycles after the impulse edge.
REQ-033 Max: c all 31, data_in all 15 -> steady final_out 1860, no overflow in the 11-bit output.
REQ-034 Gapped input: impulse with in_valid every third cycle -> out_valid pattern identical to the in_valid pattern delayed 3 cycles, with values 1,2,3,4.
REQ-035 Live update: during a constant input of 1 with c={1,1,1,1} (output 4), write c[0]=5 -> output becomes 8 exactly LAT-1 cycles after the write edge.
REQ-036 Disturbance: assert RESET mid-stream -> final_out=0, out_valid=0 immediately and all coefficients read back as 0; clear mid-stream -> output 0 next cycle and coefficients retained, so the next impulse yields 1,2,3,4.
REQ-037 Illegal address: coef_wr with coef_addr>=TAPS (TAPS=3 build) -> no coefficient changes.

Source files
------------

// File: rtl/sop_pkg.sv
// sop_pkg: shared constants and width helpers for the sop_fir_pipe FIR filter.
//   DEF_WIDTH / DEF_TAPS : default sample width and tap count
//   sop_aw  : coefficient address width, clog2(taps)
//   sop_ow  : full-precision output width, width + cwidth + clog2(taps)
//   sop_lat : in_valid-to-out_valid latency in edges, 2 + clog2(taps)
package sop_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_TAPS  = 4;

  function automatic int unsigned sop_aw(input int unsigned taps);
    return $clog2(taps);
  endfunction

  function automatic int unsigned sop_ow(input int unsigned width, input int unsigned cwidth,
                                         input int unsigned taps);
    return width + cwidth + $clog2(taps);
  endfunction

  function automatic int unsigned sop_lat(input int unsigned taps);
    return 2 + $clog2(taps);
  endfunction

endpackage

// File: rtl/sop_tap.sv
// sop_tap: one FIR tap -- delay-line word, coefficient register and product register.
//   clk, rst_n  : clock, asynchronous active-low (already synchronised) reset
//   clear       : synchronous flush of delay word and product (coefficient kept)
//   shift       : load din into the delay word
//   din         : previous tap's delay word (or the input sample for tap 0)
//   coef_we     : write coef_wdata into the coefficient register
//   prod_en     : register a new product this edge
//   dout        : this tap's delay word, forwarded to the next tap
//   prod        : registered unsigned product dout * coefficient
module sop_tap #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CWIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     shift,
  input  logic [WIDTH-1:0]         din,
  input  logic                     coef_we,
  input  logic [CWIDTH-1:0]        coef_wdata,
  input  logic                     prod_en,
  output logic [WIDTH-1:0]         dout,
  output logic [WIDTH+CWIDTH-1:0]  prod
);

  localparam int unsigned PW = WIDTH + CWIDTH;

  logic [WIDTH-1:0]  dly_q;
  logic [CWIDTH-1:0] coef_q;
  logic [PW-1:0]     prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q  <= '0;
      coef_q <= '0;
      prod_q <= '0;
    end else begin
      // clear wins over a simultaneous shift; coefficients survive a clear
      if (clear) begin
        dly_q <= '0;
      end else if (shift) begin
        dly_q <= din;
      end

      if (coef_we) begin
        coef_q <= coef_wdata;
      end

      if (clear) begin
        prod_q <= '0;
      end else if (prod_en) begin
        prod_q <= PW'(dly_q) * PW'(coef_q);
      end
    end
  end

  assign dout = dly_q;
  assign prod = prod_q;

endmodule

// File: rtl/sop_fir_pipe.sv
// sop_fir_pipe: pipelined sum-of-products FIR, y[n] = sum_k c[k] * x[n-k], unsigned,
// full precision. One sample per cycle, no backpressure.
//   CLK        : clock, rising edge
//   RESET      : asynchronous active-low reset (deassertion synchronised internally)
//   clear      : synchronous flush of data path and valid pipe; coefficients kept
//   in_valid   : data_in carries a sample
//   data_in    : sample x[n]
//   coef_wr    : coefficient write strobe
//   coef_addr  : tap index for the write (indices >= TAPS are ignored)
//   coef_data  : coefficient value
//   out_valid  : final_out holds a new result
//   final_out  : filter output, held while out_valid is low
// Pipeline: delay line (edge 0), products (edge 1), then one registered adder-tree level
// per edge; the root level is final_out itself.
module sop_fir_pipe
  import sop_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned CWIDTH = WIDTH + 1,
  parameter int unsigned TAPS   = DEF_TAPS
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   clear,
  input  logic                                   in_valid,
  input  logic [WIDTH-1:0]                       data_in,
  input  logic                                   coef_wr,
  input  logic [sop_aw(TAPS)-1:0]                coef_addr,
  input  logic [CWIDTH-1:0]                      coef_data,
  output logic                                   out_valid,
  output logic [sop_ow(WIDTH, CWIDTH, TAPS)-1:0] final_out
);

  localparam int unsigned AW  = sop_aw(TAPS);
  localparam int unsigned OW  = sop_ow(WIDTH, CWIDTH, TAPS);
  localparam int unsigned LAT = sop_lat(TAPS);
  localparam int unsigned PW  = WIDTH + CWIDTH;
  localparam int unsigned L   = AW;        // adder-tree levels
  localparam int unsigned N   = 1 << L;    // tree leaves, zero-padded above TAPS

  // Reset cell: assert asynchronously, release two edges after RESET rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Valid pipe: bit t marks stage t holding a live sample (0 = delay line,
  // 1 = products, 2.. = tree levels); the top bit is out_valid.
  logic [LAT-1:0] v_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (clear) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[LAT-2:0], in_valid};
    end
  end

  assign out_valid = v_q[LAT-1];

  // Taps
  logic [WIDTH-1:0] dly  [TAPS];
  logic [PW-1:0]    prod [TAPS];

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic [WIDTH-1:0] tap_in;

    if (k == 0) begin : g_first
      assign tap_in = data_in;
    end else begin : g_next
      assign tap_in = dly[k-1];
    end

    sop_tap #(
      .WIDTH  (WIDTH),
      .CWIDTH (CWIDTH)
    ) u_tap (
      .clk        (CLK),
      .rst_n      (rst_n),
      .clear      (clear),
      .shift      (in_valid),
      .din        (tap_in),
      .coef_we    (coef_wr && (coef_addr == AW'(k))),
      .coef_wdata (coef_data),
      .prod_en    (v_q[0]),
      .dout       (dly[k]),
      .prod       (prod[k])
    );
  end

  // Adder tree stored as a heap: node j has children 2j and 2j+1, node 1 is the root,
  // heap entries N..2N-1 are the (zero-extended, zero-padded) products.
  logic [OW-1:0] node_q [1:N-1];
  logic [OW-1:0] heap   [2*N];

  always_comb begin
    for (int j = 0; j < 2 * N; j++) begin
      heap[j] = '0;
    end
    for (int j = 1; j < N; j++) begin
      heap[j] = node_q[j];
    end
    for (int i = 0; i < TAPS; i++) begin
      heap[N+i] = OW'(prod[i]);
    end
  end

  // A node at depth d belongs to tree level L-d and loads only when the stage feeding
  // it is valid, so the root (final_out) holds between results.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 1; j < N; j++) begin
        node_q[j] <= '0;
      end
    end else if (clear) begin
      for (int j = 1; j < N; j++) begin
        node_q[j] <= '0;
      end
    end else begin
      for (int d = 0; d < L; d++) begin
        for (int i = 0; i < (1 << d); i++) begin
          if (v_q[L-d]) begin
            node_q[(1<<d)+i] <= heap[2*((1<<d)+i)] + heap[2*((1<<d)+i)+1];
          end
        end
      end
    end
  end

  assign final_out = node_q[1];

endmodule

// File: tb/tb_sop_fir_pipe.sv
module tb_sop_fir_pipe;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        clear, in_valid, coef_wr;
  logic [3:0]  data_in;
  logic [1:0]  coef_addr;
  logic [4:0]  coef_data;
  logic        out_valid;
  logic [10:0] final_out;

  logic        t3_clear, t3_in_valid, t3_coef_wr;
  logic [3:0]  t3_data_in;
  logic [1:0]  t3_coef_addr;
  logic [4:0]  t3_coef_data;
  logic        t3_out_valid;
  logic [10:0] t3_final_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  sop_fir_pipe dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear     (clear),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .final_out (final_out)
  );

  sop_fir_pipe #(.TAPS(3)) dut3 (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear     (t3_clear),
    .in_valid  (t3_in_valid),
    .data_in   (t3_data_in),
    .coef_wr   (t3_coef_wr),
    .coef_addr (t3_coef_addr),
    .coef_data (t3_coef_data),
    .out_valid (t3_out_valid),
    .final_out (t3_final_out)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    data_in  = '0;
    repeat (n) tick();
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [4:0] d);
    coef_wr = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_wr = 1'b0;
  endtask

  task automatic load4(input logic [4:0] c0, input logic [4:0] c1,
                       input logic [4:0] c2, input logic [4:0] c3);
    wr_coef(2'd0, c0); wr_coef(2'd1, c1); wr_coef(2'd2, c2); wr_coef(2'd3, c3);
  endtask

  task automatic t3_wr_coef(input logic [1:0] a, input logic [4:0] d);
    t3_coef_wr = 1'b1; t3_coef_addr = a; t3_coef_data = d;
    tick();
    t3_coef_wr = 1'b0;
  endtask

  task automatic test_reset();
    clear = 0; in_valid = 0; coef_wr = 0; data_in = 0; coef_addr = 0; coef_data = 0;
    t3_clear = 0; t3_in_valid = 0; t3_coef_wr = 0; t3_data_in = 0;
    t3_coef_addr = 0; t3_coef_data = 0;
    #1 RESET = 1'b0;
    #2;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset out_valid got %0b exp 0", out_valid);
    end
    n_tests++;
    if (final_out !== 11'd0) begin
      n_fail++; $display("FAIL reset final_out got %0d exp 0", final_out);
    end
    n_tests++;
    if (t3_out_valid !== 1'b0 || t3_final_out !== 11'd0) begin
      n_fail++;
      $display("FAIL reset taps3 got ov=%0b y=%0d exp ov=0 y=0", t3_out_valid, t3_final_out);
    end
    tick(); tick();
    RESET = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_impulse();
    int vals [5];
    vals = '{1, 2, 3, 4, 0};
    load4(5'd1, 5'd2, 5'd3, 5'd4);
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      data_in  = (c == 0) ? 4'd1 : 4'd0;
      tick();
      n_tests++;
      if (out_valid !== (c >= 3)) begin
        n_fail++; $display("FAIL impulse c=%0d out_valid got %0b exp %0b", c, out_valid, c >= 3);
      end
      n_tests++;
      if (final_out !== ((c >= 3) ? 11'(vals[c-3]) : 11'd0)) begin
        n_fail++;
        $display("FAIL impulse c=%0d final_out got %0d exp %0d", c, final_out,
                 (c >= 3) ? vals[c-3] : 0);
      end
    end
    idle(1);
  endtask

  task automatic test_max();
    load4(5'd31, 5'd31, 5'd31, 5'd31);
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      data_in  = 4'd15;
      tick();
      if (c >= 6) begin
        n_tests++;
        if (final_out !== 11'd1860 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL max c=%0d got ov=%0b y=%0d exp ov=1 y=1860", c, out_valid, final_out);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_gapped();
    int vals [5];
    logic [10:0] exp_y;
    logic        exp_ov;
    vals = '{1, 2, 3, 4, 0};
    load4(5'd1, 5'd2, 5'd3, 5'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_y = 11'd0;
    for (int c = 0; c < 18; c++) begin
      in_valid = ((c % 3) == 0) && (c <= 12);
      data_in  = (c == 0) ? 4'd1 : 4'd0;
      tick();
      exp_ov = (c >= 3) && (((c - 3) % 3) == 0) && (c <= 15);
      if (exp_ov) exp_y = 11'(vals[(c-3)/3]);
      n_tests++;
      if (out_valid !== exp_ov || final_out !== exp_y) begin
        n_fail++;
        $display("FAIL gapped c=%0d got ov=%0b y=%0d exp ov=%0b y=%0d", c, out_valid,
                 final_out, exp_ov, exp_y);
      end
    end
    idle(1);
  endtask

  task automatic test_live_update();
    load4(5'd1, 5'd1, 5'd1, 5'd1);
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; data_in = 4'd1;
      tick();
    end
    n_tests++;
    if (final_out !== 11'd4) begin
      n_fail++; $display("FAIL live steady got %0d exp 4", final_out);
    end
    coef_wr = 1'b1; coef_addr = 2'd0; coef_data = 5'd5;
    tick();
    coef_wr = 1'b0;
    for (int m = 0; m < 5; m++) begin
      n_tests++;
      if (final_out !== ((m >= 3) ? 11'd8 : 11'd4)) begin
        n_fail++;
        $display("FAIL live m=%0d got %0d exp %0d", m, final_out, (m >= 3) ? 8 : 4);
      end
      tick();
    end
    idle(1);
  endtask

  task automatic test_clear();
    load4(5'd1, 5'd2, 5'd3, 5'd4);
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; data_in = 4'd7;
      tick();
    end
    clear = 1'b1; in_valid = 1'b1; data_in = 4'd9;
    tick();
    clear = 1'b0; in_valid = 1'b0; data_in = 4'd0;
    n_tests++;
    if (out_valid !== 1'b0 || final_out !== 11'd0) begin
      n_fail++; $display("FAIL clear got ov=%0b y=%0d exp ov=0 y=0", out_valid, final_out);
    end
    for (int m = 0; m < 4; m++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL clear_quiet m=%0d out_valid got %0b exp 0", m, out_valid);
      end
    end
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1;
      data_in  = (c == 0) ? 4'd1 : 4'd0;
      tick();
      if (c >= 3) begin
        n_tests++;
        if (out_valid !== 1'b1 || final_out !== 11'(c - 2)) begin
          n_fail++;
          $display("FAIL clear_impulse c=%0d got ov=%0b y=%0d exp ov=1 y=%0d", c, out_valid,
                   final_out, c - 2);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; data_in = 4'd1;
      tick();
    end
    #2 RESET = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || final_out !== 11'd0) begin
      n_fail++; $display("FAIL midreset got ov=%0b y=%0d exp ov=0 y=0", out_valid, final_out);
    end
    in_valid = 1'b0; data_in = 4'd0;
    tick();
    RESET = 1'b1;
    for (int m = 0; m < 6; m++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || final_out !== 11'd0) begin
        n_fail++;
        $display("FAIL midreset_quiet m=%0d got ov=%0b y=%0d exp ov=0 y=0", m, out_valid,
                 final_out);
      end
    end
    // Coefficients were reset: an impulse must yield zeros.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      data_in  = (c == 0) ? 4'd1 : 4'd0;
      tick();
      if (c >= 3) begin
        n_tests++;
        if (out_valid !== 1'b1 || final_out !== 11'd0) begin
          n_fail++;
          $display("FAIL coef_zero c=%0d got ov=%0b y=%0d exp ov=1 y=0", c, out_valid,
                   final_out);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    // Write c[0]=3 on the same edge that shifts in x=2; only c[0] is non-zero.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      data_in  = (c == 0) ? 4'd2 : 4'd0;
      coef_wr  = (c == 0); coef_addr = 2'd0; coef_data = 5'd3;
      tick();
      coef_wr = 1'b0;
      if (c >= 3) begin
        n_tests++;
        if (out_valid !== 1'b1 || final_out !== ((c == 3) ? 11'd6 : 11'd0)) begin
          n_fail++;
          $display("FAIL simul c=%0d got ov=%0b y=%0d exp ov=1 y=%0d", c, out_valid,
                   final_out, (c == 3) ? 6 : 0);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_illegal_addr();
    int vals [4];
    vals = '{1, 2, 3, 0};
    t3_wr_coef(2'd0, 5'd1);
    t3_wr_coef(2'd1, 5'd2);
    t3_wr_coef(2'd2, 5'd3);
    t3_wr_coef(2'd3, 5'd31);
    for (int c = 0; c < 7; c++) begin
      t3_in_valid = 1'b1;
      t3_data_in  = (c == 0) ? 4'd1 : 4'd0;
      tick();
      n_tests++;
      if (t3_out_valid !== (c >= 3) ||
          t3_final_out !== ((c >= 3) ? 11'(vals[c-3]) : 11'd0)) begin
        n_fail++;
        $display("FAIL illegal_addr c=%0d got ov=%0b y=%0d exp ov=%0b y=%0d", c, t3_out_valid,
                 t3_final_out, c >= 3, (c >= 3) ? vals[c-3] : 0);
      end
    end
    t3_in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_max();
    test_gapped();
    test_live_update();
    test_clear();
    test_reset_midstream();
    test_back_to_back();
    test_illegal_addr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
